// File: rtl/vect_lane_serializer_if.sv
// Handshake bundle for vect_lane_serializer: vector intake from the vector pipe,
// scalar lane output towards the store unit / scalar writeback port.
interface vect_lane_serializer_if #(
  parameter int WIDTH        = 8,
  parameter int registerSize = 32,
  parameter int vectorSize   = 4
) ();
  localparam int LW = $clog2(vectorSize);

  logic                                     flush;
  logic                                     in_valid;
  logic                                     in_ready;
  logic [vectorSize-1:0][registerSize-1:0]  vect;
  logic [vectorSize-1:0]                    lane_mask;
  logic [WIDTH-1:0]                         tag;
  logic                                     out_valid;
  logic                                     out_ready;
  logic [registerSize-1:0]                  out_data;
  logic [LW-1:0]                            out_lane;
  logic [WIDTH-1:0]                         out_tag;
  logic                                     out_last;

  // Producer/consumer side of the serializer.
  modport master (
    output flush, in_valid, vect, lane_mask, tag, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_tag, out_last
  );

  // The serializer itself.
  modport slave (
    input  flush, in_valid, vect, lane_mask, tag, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_tag, out_last
  );
endinterface

// File: rtl/vect_lane_serializer.sv
// Serializes the enabled lanes of one packed vector onto a scalar valid/ready port,
// lowest enabled lane first, with the control tag repeated on every beat.
module vect_lane_serializer #(
  parameter int WIDTH        = 8,
  parameter int registerSize = 32,
  parameter int vectorSize   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  vect_lane_serializer_if.slave  bus
);
  localparam int LW = $clog2(vectorSize);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]                               state_q, state_d;
  logic [vectorSize-1:0][registerSize-1:0]  vect_q, vect_d;
  logic [vectorSize-1:0]                    mask_q, mask_d;  // lanes still pending behind the current one
  logic [WIDTH-1:0]                         tag_q, tag_d;
  logic [LW-1:0]                            lane_q, lane_d;
  logic                                     last_q, last_d;

  logic          accept, pop;
  logic [LW-1:0] load_lane, next_lane;

  function automatic logic [LW-1:0] lowest_lane(input logic [vectorSize-1:0] m);
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = vectorSize - 1; i >= 0; i--) begin
      if (m[i]) idx = LW'(i);
    end
    return idx;
  endfunction

  function automatic logic [vectorSize-1:0] lane_bit(input logic [LW-1:0] l);
    logic [vectorSize-1:0] b;
    b    = '0;
    b[l] = 1'b1;
    return b;
  endfunction

  // A new vector may enter while the last lane of the current one is being popped.
  assign bus.in_ready = (state_q == ST_IDLE) | ((state_q == ST_SEND) & bus.out_ready & last_q);
  assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
  assign pop          = (state_q == ST_SEND) & bus.out_ready & ~bus.flush;
  assign load_lane    = lowest_lane(bus.lane_mask);
  assign next_lane    = lowest_lane(mask_q);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the ifs infers a latch.
    state_d = state_q;
    vect_d  = vect_q;
    mask_d  = mask_q;
    tag_d   = tag_q;
    lane_d  = lane_q;
    last_d  = last_q;

    if (bus.flush) begin
      state_d = ST_IDLE;
      mask_d  = '0;
    end else if (accept) begin
      vect_d = bus.vect;
      tag_d  = bus.tag;
      if (bus.lane_mask != '0) begin
        state_d = ST_SEND;
        lane_d  = load_lane;
        mask_d  = bus.lane_mask & ~lane_bit(load_lane);
        last_d  = ((bus.lane_mask & ~lane_bit(load_lane)) == '0);
      end else begin
        state_d = ST_IDLE;
        mask_d  = '0;
      end
    end else if (pop) begin
      if (last_q) begin
        state_d = ST_IDLE;
      end else begin
        lane_d = next_lane;
        mask_d = mask_q & ~lane_bit(next_lane);
        last_d = ((mask_q & ~lane_bit(next_lane)) == '0);
      end
    end
  end

  // NOTE: held vector is a plain register bank, reset so out_data reads zero straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      vect_q  <= '0;
      mask_q  <= '0;
      tag_q   <= '0;
      lane_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      vect_q  <= vect_d;
      mask_q  <= mask_d;
      tag_q   <= tag_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
    end
  end

  assign bus.out_valid = (state_q == ST_SEND);
  assign bus.out_data  = vect_q[lane_q];
  assign bus.out_lane  = lane_q;
  assign bus.out_tag   = tag_q;
  assign bus.out_last  = last_q;
endmodule

// File: tb/tb_vect_lane_serializer.sv
// Scoreboard bench for vect_lane_serializer: driver pushes the expected lane beats of each
// accepted vector, a negedge monitor pops and compares every transferred beat.
module tb_vect_lane_serializer;
  localparam int WIDTH = 8;
  localparam int RS    = 32;
  localparam int VS    = 4;
  localparam int LW    = 2;

  typedef logic [VS-1:0][RS-1:0] vec_t;

  typedef struct packed {
    logic [RS-1:0]    data;
    logic [LW-1:0]    lane;
    logic [WIDTH-1:0] tag;
    logic             last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic rand_mode = 1'b0;
  logic rand_bit  = 1'b1;
  logic dir_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  beat_t exp_q[$];
  int    beat_cyc[$];

  logic  prev_stall = 1'b0;
  beat_t prev_out;

  always #5 clk = ~clk;

  vect_lane_serializer_if #(.WIDTH(WIDTH), .registerSize(RS), .vectorSize(VS)) bus ();

  vect_lane_serializer #(.WIDTH(WIDTH), .registerSize(RS), .vectorSize(VS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.out_ready = rand_mode ? rand_bit : dir_ready;

  always @(posedge clk) begin
    cycle    <= cycle + 1;
    rand_bit <= ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference: enabled lanes in ascending order, last flag on the highest enabled lane.
  task automatic push_model(input vec_t v, input logic [VS-1:0] m, input logic [WIDTH-1:0] t);
    int    highest;
    beat_t b;
    highest = -1;
    for (int i = 0; i < VS; i++) if (m[i]) highest = i;
    for (int i = 0; i < VS; i++) begin
      if (m[i]) begin
        b.data = v[i];
        b.lane = LW'(i);
        b.tag  = t;
        b.last = (i == highest);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic monitor_step();
    beat_t e;
    if (reset !== 1'b1) return;
    if (prev_stall) begin
      check("stall_valid", bus.out_valid, 1'b1);
      check("stall_data",  bus.out_data,  prev_out.data);
      check("stall_lane",  bus.out_lane,  prev_out.lane);
      check("stall_tag",   bus.out_tag,   prev_out.tag);
      check("stall_last",  bus.out_last,  prev_out.last);
    end
    if (bus.out_valid && bus.out_ready && !bus.flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", bus.out_data, e.data);
        check("beat_lane", bus.out_lane, e.lane);
        check("beat_tag",  bus.out_tag,  e.tag);
        check("beat_last", bus.out_last, e.last);
        beat_cyc.push_back(cycle);
      end
    end
  endtask

  always @(negedge clk) begin
    monitor_step();
    prev_stall    <= (reset === 1'b1) && bus.out_valid && !bus.out_ready && !bus.flush;
    prev_out.data <= bus.out_data;
    prev_out.lane <= bus.out_lane;
    prev_out.tag  <= bus.out_tag;
    prev_out.last <= bus.out_last;
  end

  // Presents a vector from posedge+1, returns at posedge+1 after the accepting edge.
  task automatic send_vec(input vec_t v, input logic [VS-1:0] m, input logic [WIDTH-1:0] t);
    bit ok;
    bus.vect      = v;
    bus.lane_mask = m;
    bus.tag       = t;
    bus.in_valid  = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.in_ready && !bus.flush) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) push_model(v, m, t);
    else check("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    bit done;
    done = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_timeout", done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_consec(input string name, input int n);
    int sz;
    sz = beat_cyc.size();
    if (sz < n) begin
      check(name, sz, n);
      return;
    end
    for (int j = 1; j < n; j++)
      check(name, beat_cyc[sz-n+j] - beat_cyc[sz-n+j-1], 1);
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < VS; i++) v[i] = $urandom;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   nb;

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.vect      = '0;
    bus.lane_mask = '0;
    bus.tag       = '0;
    reset         = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data",  bus.out_data,  '0);
    check("rst_out_lane",  bus.out_lane,  '0);
    check("rst_out_tag",   bus.out_tag,   '0);
    check("rst_out_last",  bus.out_last,  1'b0);
    check("rst_in_ready",  bus.in_ready,  1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Full mask, known data.
    v = {32'h33, 32'h22, 32'h11, 32'h00};
    send_vec(v, 4'hF, 8'hA5);
    wait_drain(50);
    check_consec("t2_consecutive", 4);

    // Sparse mask, then empty mask.
    send_vec(rand_vec(), 4'b1010, 8'h3C);
    wait_drain(50);
    nb = beat_cyc.size();
    send_vec(rand_vec(), 4'b0000, 8'h77);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("zero_mask_valid", bus.out_valid, 1'b0);
      check("zero_mask_ready", bus.in_ready,  1'b1);
    end
    check("zero_mask_beats", beat_cyc.size(), nb);
    @(posedge clk);
    #1;

    // Stall on lane 2.
    v = rand_vec();
    send_vec(v, 4'hF, 8'h5A);
    repeat (2) @(posedge clk);
    #1;
    check("stall_at_lane2", bus.out_lane, 2'd2);
    dir_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall4_valid", bus.out_valid, 1'b1);
      check("stall4_lane",  bus.out_lane,  2'd2);
      check("stall4_data",  bus.out_data,  v[2]);
      check("stall4_ready", bus.in_ready,  1'b0);
    end
    @(posedge clk);
    #1;
    dir_ready = 1'b1;
    wait_drain(50);

    // Back-to-back full vectors.
    send_vec(rand_vec(), 4'hF, 8'h11);
    send_vec(rand_vec(), 4'hF, 8'h22);
    wait_drain(50);
    check_consec("b2b_consecutive", 8);

    // Flush while lane 1 is presented.
    send_vec(rand_vec(), 4'hF, 8'h99);
    @(posedge clk);
    #1;
    check("flush_at_lane1", bus.out_lane, 2'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_valid", bus.out_valid, 1'b0);
    check("flush_ready", bus.in_ready,  1'b1);
    check("flush_lane_hold", bus.out_lane, 2'd1);
    @(posedge clk);
    #1;
    send_vec(rand_vec(), 4'hF, 8'h44);
    wait_drain(50);

    // Reset while a lane is stalled.
    dir_ready = 1'b0;
    send_vec(rand_vec(), 4'hF, 8'hEE);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_valid", bus.out_valid, 1'b0);
    check("midrst_data",  bus.out_data,  '0);
    check("midrst_lane",  bus.out_lane,  '0);
    check("midrst_tag",   bus.out_tag,   '0);
    check("midrst_last",  bus.out_last,  1'b0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    dir_ready = 1'b1;
    @(negedge clk);
    check("postrst_ready", bus.in_ready,  1'b1);
    check("postrst_valid", bus.out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure.
    rand_mode = 1'b1;
    for (int n = 0; n < 40; n++)
      send_vec(rand_vec(), VS'($urandom_range(0, 15)), WIDTH'($urandom));
    wait_drain(2000);
    rand_mode = 1'b0;
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
